// File: rtl/dualshock_poller.sv
// dualshock_poller: round-robin DualShock 2 poller. A byte-wide SPI master (mode 3,
// LSB first) that selects each pad in turn, sends 0x01 0x42 0x00..., decodes the
// reply ID and updates that pad's button / stick / mode / presence record.
// Build option: define DUALSHOCK_ANALOG_EN to clock 6 data bytes for analog IDs and
// capture the four stick axes; without it only 2 data bytes are clocked and the
// stick outputs are the constant centre value.
module dualshock_poller #(
    parameter int unsigned CLK_RATIO = 750,
    parameter int unsigned NUM_PADS  = 2,
    parameter int unsigned BYTE_GAP  = 2,
    parameter int unsigned FRAME_GAP = 8,
    localparam int unsigned PW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   spi_miso,
    output logic                   spi_clk,
    output logic                   spi_mosi,
    output logic [NUM_PADS-1:0]    spi_cs,
    output logic                   data_valid,
    output logic [PW-1:0]          pad_index,
    output logic [NUM_PADS*16-1:0] buttons,
    output logic [NUM_PADS*32-1:0] sticks,
    output logic [NUM_PADS-1:0]    analog,
    output logic [NUM_PADS-1:0]    present
);

    localparam int unsigned HALF   = CLK_RATIO / 2;
    localparam int unsigned CW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned GAP_H  = 2 * BYTE_GAP;
    localparam int unsigned WAIT_H = 2 * FRAME_GAP;
    localparam int unsigned HMAX   = (GAP_H > WAIT_H) ? ((GAP_H > 16) ? GAP_H : 16)
                                                      : ((WAIT_H > 16) ? WAIT_H : 16);
    localparam int unsigned HW     = $clog2(HMAX);
    localparam logic [31:0] STICK_IDLE = 32'h8080_8080;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        XFER,
        GAP,
        DESELECT,
        UPDATE,
        FRAME_WAIT
    } state_t;

    state_t          state;
    logic [CW-1:0]   div_cnt;
    logic            tick;
    logic [HW-1:0]   hcnt;
    logic [PW-1:0]   pad_q;
    logic [3:0]      byte_idx;
    logic [2:0]      bit_q;
    logic [7:0]      rx_q;
    logic [7:0]      id_q;
    logic [7:0]      hdr_q;
    logic [7:0]      btn_lo;
    logic [7:0]      btn_hi;
`ifdef DUALSHOCK_ANALOG_EN
    logic [31:0]     stick_cap;
`endif

    logic [7:0]          tx_c;
    logic                long_c;
    logic [3:0]          last_idx_c;
    logic                hdr_ok_c;
    logic [NUM_PADS-1:0] select_c;

    // Free-running half-period divider; tick marks every SPI half period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick = (div_cnt == CW'(HALF - 1));

    // Command byte for the current position in the frame
    always_comb begin
        tx_c = 8'h00;
        if (byte_idx == 4'd0) begin
            tx_c = 8'h01;
        end else if (byte_idx == 4'd1) begin
            tx_c = 8'h42;
        end
    end

`ifdef DUALSHOCK_ANALOG_EN
    // IDs with a length nibble of 3 or more carry six data bytes, everything else two
    assign long_c = (id_q[3:0] >= 4'd3);
`else
    assign long_c = 1'b0;
`endif

    assign last_idx_c = long_c ? 4'd8 : 4'd4;
    assign hdr_ok_c   = (hdr_q == 8'h5A);
    assign select_c   = ~(NUM_PADS'(1) << pad_q);

    // Frame sequencer: chip select, SPI clock, MOSI shifting, MISO capture, record update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            pad_q      <= '0;
            byte_idx   <= '0;
            bit_q      <= '0;
            rx_q       <= '0;
            id_q       <= '0;
            hdr_q      <= '0;
            btn_lo     <= 8'hFF;
            btn_hi     <= 8'hFF;
            spi_clk    <= 1'b1;
            spi_mosi   <= 1'b1;
            spi_cs     <= '1;
            data_valid <= 1'b0;
            pad_index  <= '0;
            buttons    <= '1;
            analog     <= '0;
            present    <= '0;
`ifdef DUALSHOCK_ANALOG_EN
            stick_cap  <= STICK_IDLE;
            sticks     <= {NUM_PADS{STICK_IDLE}};
`endif
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        state    <= SELECT;
                        hcnt     <= '0;
                        byte_idx <= '0;
                        spi_cs   <= select_c;
                    end
                end
                SELECT: begin
                    if (tick) begin
                        if (hcnt == HW'(1)) begin
                            state    <= XFER;
                            hcnt     <= '0;
                            spi_clk  <= 1'b0;
                            spi_mosi <= tx_c[0];
                            bit_q    <= 3'd1;
                        end else begin
                            hcnt <= hcnt + HW'(1);
                        end
                    end
                end
                XFER: begin
                    if (tick) begin
                        hcnt <= hcnt + HW'(1);
                        if (hcnt == HW'(15)) begin
                            // Half period after the 8th rising edge: byte is complete
                            hcnt     <= '0;
                            spi_mosi <= 1'b1;
                            case (byte_idx)
                                4'd1: id_q   <= rx_q;
                                4'd2: hdr_q  <= rx_q;
                                4'd3: btn_lo <= rx_q;
                                4'd4: btn_hi <= rx_q;
`ifdef DUALSHOCK_ANALOG_EN
                                4'd5: stick_cap[7:0]   <= rx_q;
                                4'd6: stick_cap[15:8]  <= rx_q;
                                4'd7: stick_cap[23:16] <= rx_q;
                                4'd8: stick_cap[31:24] <= rx_q;
`endif
                                default: ;
                            endcase
                            if ((byte_idx == 4'd2 && rx_q != 8'h5A) || byte_idx == last_idx_c) begin
                                state <= DESELECT;
                            end else begin
                                state    <= GAP;
                                byte_idx <= byte_idx + 4'd1;
                            end
                        end else if (hcnt[0]) begin
                            spi_clk  <= 1'b0;
                            spi_mosi <= tx_c[bit_q];
                            bit_q    <= bit_q + 3'd1;
                        end else begin
                            spi_clk <= 1'b1;
                            rx_q    <= {spi_miso, rx_q[7:1]};
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (hcnt == HW'(GAP_H - 1)) begin
                            state    <= XFER;
                            hcnt     <= '0;
                            spi_clk  <= 1'b0;
                            spi_mosi <= tx_c[0];
                            bit_q    <= 3'd1;
                        end else begin
                            hcnt <= hcnt + HW'(1);
                        end
                    end
                end
                DESELECT: begin
                    // Trailing CS hold period, then release the pad
                    if (tick) begin
                        if (hcnt == HW'(1)) begin
                            state  <= UPDATE;
                            hcnt   <= '0;
                            spi_cs <= '1;
                        end else begin
                            hcnt <= hcnt + HW'(1);
                        end
                    end
                end
                UPDATE: begin
                    data_valid <= 1'b1;
                    pad_index  <= pad_q;
                    for (int p = 0; p < NUM_PADS; p++) begin
                        if (pad_q == PW'(p)) begin
                            present[p]         <= hdr_ok_c;
                            analog[p]          <= hdr_ok_c && (id_q == 8'h73);
                            buttons[p*16 +: 16] <= hdr_ok_c ? {btn_hi, btn_lo} : 16'hFFFF;
`ifdef DUALSHOCK_ANALOG_EN
                            sticks[p*32 +: 32]  <= (hdr_ok_c && long_c) ? stick_cap : STICK_IDLE;
`endif
                        end
                    end
                    if (pad_q == PW'(NUM_PADS - 1)) begin
                        pad_q <= '0;
                    end else begin
                        pad_q <= pad_q + PW'(1);
                    end
                    state <= FRAME_WAIT;
                    hcnt  <= '0;
                end
                FRAME_WAIT: begin
                    if (tick) begin
                        if (hcnt == HW'(WAIT_H - 1)) begin
                            state <= IDLE;
                            hcnt  <= '0;
                        end else begin
                            hcnt <= hcnt + HW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef DUALSHOCK_ANALOG_EN
    // Without stick capture the axes always read centred
    assign sticks = {NUM_PADS{STICK_IDLE}};
`endif

endmodule

// File: tb/tb_dualshock_poller.sv
// tb_dualshock_poller: directed bench with a two-pad reply model on the shared MISO line.
module tb_dualshock_poller;

    localparam int TMO = 3000;

`ifdef DUALSHOCK_ANALOG_EN
    localparam logic [31:0] EXP_STK   = 32'h4030_2010;
    localparam int          EXP_BYTES = 9;
`else
    localparam logic [31:0] EXP_STK   = 32'h8080_8080;
    localparam int          EXP_BYTES = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        spi_miso;
    logic        spi_clk;
    logic        spi_mosi;
    logic [1:0]  spi_cs;
    logic        data_valid;
    logic [0:0]  pad_index;
    logic [31:0] buttons;
    logic [63:0] sticks;
    logic [1:0]  analog;
    logic [1:0]  present;

    int checks   = 0;
    int failures = 0;

    dualshock_poller #(
        .CLK_RATIO (4),
        .NUM_PADS  (2),
        .BYTE_GAP  (2),
        .FRAME_GAP (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spi_miso   (spi_miso),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_cs     (spi_cs),
        .data_valid (data_valid),
        .pad_index  (pad_index),
        .buttons    (buttons),
        .sticks     (sticks),
        .analog     (analog),
        .present    (present)
    );

    always #5 clk = ~clk;

    // Pad reply model: each falling SPI edge presents the next reply bit, LSB first
    logic [7:0]  rep [0:1][0:8];
    logic        desel;
    logic        miso_r = 1'b1;
    logic [7:0]  cur;
    int          edge_cnt   = 0;
    int          last_edges = 0;
    int          rise_cnt   = 0;
    logic [15:0] mosi_log   = '0;

    assign desel    = &spi_cs;
    assign spi_miso = desel ? 1'b1 : miso_r;

    always @(negedge spi_clk or posedge desel) begin
        if (desel) begin
            edge_cnt = 0;
        end else begin
            if ((edge_cnt >> 3) < 9) begin
                cur = rep[spi_cs[0] ? 1 : 0][edge_cnt >> 3];
            end else begin
                cur = 8'hFF;
            end
            miso_r = cur[edge_cnt[2:0]];
            edge_cnt++;
            last_edges = edge_cnt;
        end
    end

    // MOSI bit log taken at each rising SPI edge
    always @(posedge spi_clk or posedge desel) begin
        if (desel) begin
            rise_cnt = 0;
        end else begin
            if (rise_cnt < 16) begin
                mosi_log[rise_cnt[3:0]] = spi_mosi;
            end
            rise_cnt++;
        end
    end

    // Protocol monitors: MOSI steady over rising edges, one select at a time, no start while disabled
    int   glitch_cnt  = 0;
    int   overlap_cnt = 0;
    int   off_starts  = 0;
    logic prev_sclk   = 1'b1;
    logic prev_mosi   = 1'b1;
    logic prev_rst    = 1'b0;
    logic prev_desel  = 1'b1;

    always @(negedge clk) begin
        if (reset && prev_rst && spi_clk && !prev_sclk && spi_mosi != prev_mosi) glitch_cnt++;
        if ($countones(~spi_cs) > 1) overlap_cnt++;
        if (!enable && prev_desel && !desel) off_starts++;
        prev_sclk  = spi_clk;
        prev_mosi  = spi_mosi;
        prev_rst   = reset;
        prev_desel = desel;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int p, input logic [71:0] bytes);
        for (int i = 0; i < 9; i++) rep[p][i] = bytes[71 - 8*i -: 8];
    endtask

    // Wait for a frame to finish and check the data_valid pulse position and pad_index
    task automatic wait_frame(input string tag, input logic [0:0] exp_pad);
        int n;
        n = 0;
        while (desel && n < TMO) begin @(negedge clk); n++; end
        check({tag, "_cs_low"}, 64'(n < TMO), 64'd1);
        n = 0;
        while (!desel && n < TMO) begin @(negedge clk); n++; end
        check({tag, "_cs_high"}, 64'(n < TMO), 64'd1);
        check({tag, "_dv_early"}, 64'(data_valid), 64'd0);
        @(negedge clk);
        check({tag, "_dv"}, 64'(data_valid), 64'd1);
        check({tag, "_pad_index"}, 64'(pad_index), 64'(exp_pad));
        @(negedge clk);
        check({tag, "_dv_width"}, 64'(data_valid), 64'd0);
    endtask

    task automatic wait_edges(input string tag, input int target);
        int n;
        n = 0;
        while (edge_cnt < target && n < TMO) begin @(negedge clk); n++; end
        check({tag, "_reach"}, 64'(n < TMO), 64'd1);
    endtask

    function automatic logic [7:0] mosi_byte(input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mosi_log[b*8 + i];
        return v;
    endfunction

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        load(0, 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF);
        load(1, 72'hFF_41_5A_7F_FE_FF_FF_FF_FF);
        repeat (4) @(negedge clk);

        check("rst_spi_clk", 64'(spi_clk), 64'd1);
        check("rst_cs", 64'(spi_cs), 64'h3);
        check("rst_mosi", 64'(spi_mosi), 64'd1);
        check("rst_dv", 64'(data_valid), 64'd0);
        check("rst_pad_index", 64'(pad_index), 64'd0);
        check("rst_buttons", 64'(buttons), 64'hFFFF_FFFF);
        check("rst_sticks", sticks, 64'h8080_8080_8080_8080);
        check("rst_analog_present", 64'({analog, present}), 64'd0);

        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_disabled_cs", 64'(spi_cs), 64'h3);

        // Frame 0: pad 0 absent, aborted after the header
        enable = 1'b1;
        wait_frame("f0", 1'b0);
        check("f0_present", 64'(present[0]), 64'd0);
        check("f0_buttons", 64'(buttons[15:0]), 64'hFFFF);
        check("f0_bytes", 64'(last_edges / 8), 64'd3);

        // Frame 1: pad 1 digital
        wait_frame("f1", 1'b1);
        check("f1_buttons", 64'(buttons[31:16]), 64'hFE7F);
        check("f1_present", 64'(present[1]), 64'd1);
        check("f1_analog", 64'(analog[1]), 64'd0);
        check("f1_sticks", 64'(sticks[63:32]), 64'h8080_8080);
        check("f1_bytes", 64'(last_edges / 8), 64'd5);
        check("f1_mosi_b0", 64'(mosi_byte(0)), 64'h01);
        check("f1_mosi_b1", 64'(mosi_byte(1)), 64'h42);

        // Frame 2: pad 0 now answers in analog mode
        load(0, 72'hFF_73_5A_FF_FF_10_20_30_40);
        wait_frame("f2", 1'b0);
        check("f2_analog", 64'(analog[0]), 64'd1);
        check("f2_present", 64'(present[0]), 64'd1);
        check("f2_buttons", 64'(buttons[15:0]), 64'hFFFF);
        check("f2_sticks", 64'(sticks[31:0]), 64'(EXP_STK));
        check("f2_bytes", 64'(last_edges / 8), 64'(EXP_BYTES));
        check("f2_pad1_held", 64'(buttons[31:16]), 64'hFE7F);

        // Frame 3: enable dropped during byte 2 still completes, then the bus stays idle
        wait_edges("f3_byte2", 10);
        enable = 1'b0;
        wait_frame("f3", 1'b1);
        check("f3_buttons", 64'(buttons[31:16]), 64'hFE7F);
        begin
            int lows;
            lows = 0;
            repeat (300) begin
                @(negedge clk);
                if (!desel) lows++;
            end
            check("f3_no_new_cs", 64'(lows), 64'd0);
        end
        check("mosi_stable", 64'(glitch_cnt), 64'd0);
        check("cs_overlap", 64'(overlap_cnt), 64'd0);
        check("start_while_off", 64'(off_starts), 64'd0);

        // Frame 4: reset during byte 4 aborts everything at once
        enable = 1'b1;
        wait_edges("f4_byte4", 26);
        check("f4_pad0_selected", 64'(spi_cs), 64'h2);
        reset = 1'b0;
        #1;
        check("arst_cs", 64'(spi_cs), 64'h3);
        check("arst_spi_clk", 64'(spi_clk), 64'd1);
        check("arst_mosi", 64'(spi_mosi), 64'd1);
        check("arst_dv", 64'(data_valid), 64'd0);
        check("arst_buttons", 64'(buttons), 64'hFFFF_FFFF);
        check("arst_sticks", sticks, 64'h8080_8080_8080_8080);
        check("arst_analog_present", 64'({analog, present}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // First frame after reset targets pad 0
        begin
            int n;
            n = 0;
            while (desel && n < TMO) begin @(negedge clk); n++; end
            check("post_rst_start", 64'(n < TMO), 64'd1);
            check("post_rst_cs", 64'(spi_cs), 64'h2);
        end
        wait_frame("f5", 1'b0);
        check("f5_present", 64'(present[0]), 64'd1);
        check("f5_analog", 64'(analog[0]), 64'd1);
        check("f5_pad1_reset", 64'(buttons[31:16]), 64'hFFFF);
        check("final_overlap", 64'(overlap_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
